interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Responder side of the processor's interrupt handshake. Collects interrupt sources (internal quantum timer plus external I/O lines), prioritises them, raises `intr` toward the control unit, and on acknowledge captures the interrupt code and the interrupted PC for later `gic`/`gip` reads. It holds the request in service until the control unit's `clearIntr`. It also tracks user/kernel mode from the control unit's `userMode`/`kernelMode` pulses.

## Interface
- `NUM_EXT`, 3: number of external interrupt lines (sources 1..NUM_EXT)
- `QUANTUM`, 1000: user-mode cycles per time slice; must be ≥ 2
- `CNT_W`, 16: quantum counter width; must satisfy QUANTUM ≤ 2^CNT_W
- `clk` input 1: system clock
- `reset` input 1: synchronous, active-high
- `irq` input NUM_EXT: external interrupt lines, rising-edge sensitive; `irq[i]` is source i+1
- `pc` input 32: PC of the instruction currently executing
- `inta` input 1: interrupt acknowledge from control unit
- `clearIntr` input 1: end-of-service pulse (`cic`)
- `userMode` input 1: enter user mode (`exec`/`exec_again`)
- `kernelMode` input 1: enter kernel mode (`syscall`)
- `intr` output 1: interrupt request to control unit
- `intrCode` output 32: code of the interrupt in service; 0 = none
- `intrPc` output 32: PC captured at acceptance
- `inKernel` output 1: 1 = kernel mode

## Operation
- Source 0 is the internal quantum timer. Sources 1..NUM_EXT are `irq`. The code reported for source s is s+1.
- Edge detect: `irq_q` is registered. A rising edge on `irq[i]` (`irq[i] & ~irq_q[i]`) sets `pending[i+1]`.
- Quantum counter:
  - Increments only when `inKernel`=0 and the FSM is in IDLE.
  - When it reaches QUANTUM-1, the next cycle sets `pending[0]` and reloads the counter to 0.
  - Cleared by a `userMode` pulse and by acceptance.
- Priority: lowest pending index wins, so the timer has highest priority.
- FSM states:
  - IDLE → REQ when any pending bit is set and `inKernel`=0.
  - REQ: `intr`=1. A cycle with `intr & inta` is acceptance, with these effects:
    - `intrCode` ← winner+1
    - `intrPc` ← `pc`
    - winner's pending bit cleared
    - `inKernel` ← 1
    - next state SERVICE
  - REQ → IDLE without acceptance if `kernelMode` pulses (request withdrawn; pending kept).
  - SERVICE: `intr`=0. On `clearIntr`, `intrCode` ← 0 and state ← IDLE. `intrPc` is retained.
- Mode register:
  - `kernelMode` sets `inKernel`.
  - `userMode` clears it.
  - Acceptance sets it.
  - If `userMode` and acceptance coincide, acceptance wins.
- `clearIntr` outside SERVICE is ignored.
- A pending-set edge and a pending-clear (acceptance) on the same bit in the same cycle: set wins, so the bit stays pending.
- Sources arriving in SERVICE remain pending and are requested after return to user mode.

## Timing
- Reset values:
  - `intr`=0, `intrCode`=0, `intrPc`=0, `inKernel`=1
  - state IDLE, pending=0, counter=0, `irq_q`=0
- All outputs are registered except `intr`, which is decoded from state (state==REQ), so it has no combinational path from inputs.
- Latency:
  - `irq` rising edge to pending set: 1 cycle.
  - Pending set to `intr` high: 1 cycle (IDLE→REQ), provided `inKernel`=0.
  - Acceptance to `intrCode`/`intrPc` valid and `intr` low: 1 cycle.
- `inta` without `intr` (the `pre_io` case) has no effect on this block.
- Reset mid-service: everything returns to reset values, and all pending requests are dropped.

## Structure
- Shared package holds:
  - FSM state encoding `INTC_IDLE/INTC_REQ/INTC_SERVICE` (2 bits)
  - `INTC_CODE_NONE` = 0
  - `INTC_CODE_TIMER` = 1
- One sub-module: `intc_priority_enc` (parameterised width; returns winner index and a valid bit).

## Test plan
- After reset, with `userMode` pulsed, QUANTUM=8 and all `irq` low: `intr` rises 10 cycles after the `userMode` pulse (counter 0→7, pending set, REQ). With `inta` held and `pc`=0x40: `intrCode`=1, `intrPc`=0x40, `inKernel`=1.
- User mode, `irq[1]` 0→1 while the timer is idle: `intr` after 2 cycles. Accept → `intrCode`=3. `clearIntr` → `intrCode`=0, state IDLE.
- `irq[0]` and `irq[2]` rise in the same cycle: first acceptance gives `intrCode`=2. After `clearIntr` and a `userMode` pulse, the second gives `intrCode`=4.
- `irq[0]` rises while in SERVICE: `intr` stays 0. After `clearIntr`, `intr` stays 0 until `userMode`, then rises 1 cycle later.
- `clearIntr` pulsed in IDLE: no output change. `kernelMode` pulsed in REQ: `intr` drops, pending retained.
- `reset` asserted in SERVICE with `intrCode`=3: next cycle all outputs at reset values, and no request reappears after `userMode`.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the FSM state encoding and the reserved interrupt codes.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

  localparam logic [31:0] INTC_CODE_NONE  = 32'd0;
  localparam logic [31:0] INTC_CODE_TIMER = 32'd1;

endpackage

// File: rtl/interrupt_controller_priority_enc.sv
// Fixed-priority encoder: lowest set bit wins.
// Ports: req_i request vector, idx_o winner index, valid_o any set.
module intc_priority_enc #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest index is written last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt responder: quantum timer plus edge-triggered external lines,
// prioritised request/acknowledge/service handshake and user/kernel mode.
// Ports: clk, reset (sync, high), irq, pc, inta, clearIntr, userMode,
// kernelMode in; intr, intrCode, intrPc, inKernel out.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_EXT = 3,
  parameter int QUANTUM = 1000,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] irq,
  input  logic [31:0]        pc,
  input  logic               inta,
  input  logic               clearIntr,
  input  logic               userMode,
  input  logic               kernelMode,
  output logic               intr,
  output logic [31:0]        intrCode,
  output logic [31:0]        intrPc,
  output logic               inKernel
);

  localparam int NSRC = NUM_EXT + 1;
  localparam int IW   = $clog2(NSRC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

  intc_state_e      state_q, state_d;
  logic [NUM_EXT-1:0] irq_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      code_q, code_d;
  logic [31:0]      pc_q, pc_d;
  logic             kern_q, kern_d;

  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic [NUM_EXT-1:0] irq_rise;
  logic               accept;
  logic               cnt_en;
  logic               tmr_fire;

  intc_priority_enc #(
    .W  (NSRC),
    .IW (IW)
  ) u_enc (
    .req_i   (pend_q),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  assign irq_rise = irq & ~irq_q;
  assign accept   = (state_q == INTC_REQ) & inta & win_vld;
  assign cnt_en   = ~kern_q & (state_q == INTC_IDLE);
  assign tmr_fire = cnt_en & (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    pc_d    = pc_q;
    kern_d  = kern_q;

    // Clear before set: a new edge on the winner keeps it pending.
    if (accept) pend_d[win_idx] = 1'b0;
    pend_d = pend_d | {irq_rise, tmr_fire};

    if (tmr_fire)    cnt_d = '0;
    else if (cnt_en) cnt_d = cnt_q + CNT_W'(1);
    if (userMode | accept) cnt_d = '0;

    unique case (state_q)
      INTC_IDLE: begin
        if ((|pend_q) & ~kern_q) state_d = INTC_REQ;
      end
      INTC_REQ: begin
        if (accept) begin
          state_d = INTC_SERVICE;
          code_d  = 32'(win_idx) + INTC_CODE_TIMER;
          pc_d    = pc;
        end else if (kernelMode) begin
          state_d = INTC_IDLE;
        end
      end
      INTC_SERVICE: begin
        if (clearIntr) begin
          state_d = INTC_IDLE;
          code_d  = INTC_CODE_NONE;
        end
      end
      default: state_d = INTC_IDLE;
    endcase

    // Acceptance overrides a coincident userMode.
    if (userMode)   kern_d = 1'b0;
    if (kernelMode) kern_d = 1'b1;
    if (accept)     kern_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTC_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      code_q  <= INTC_CODE_NONE;
      pc_q    <= '0;
      kern_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      kern_q  <= kern_d;
    end
  end

  assign intr     = (state_q == INTC_REQ);
  assign intrCode = code_q;
  assign intrPc   = pc_q;
  assign inKernel = kern_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed handshake scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_interrupt_controller;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  irq;
  logic [31:0] pc;
  logic        inta, clearIntr, userMode, kernelMode;
  logic        intr, inKernel;
  logic [31:0] intrCode, intrPc;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  bit          m_req, m_svc, m_kern;
  bit [3:0]    m_pend;
  int          m_user_cycles;
  logic [2:0]  m_prev;
  logic [31:0] m_code, m_pc;

  interrupt_controller #(
    .NUM_EXT (3),
    .QUANTUM (Q),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .pc         (pc),
    .inta       (inta),
    .clearIntr  (clearIntr),
    .userMode   (userMode),
    .kernelMode (kernelMode),
    .intr       (intr),
    .intrCode   (intrCode),
    .intrPc     (intrPc),
    .inKernel   (inKernel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit acc, idle, fire;
    int w;
    bit [3:0] np;
    @(posedge clk);
    if (reset) begin
      m_req = 0; m_svc = 0; m_kern = 1; m_pend = '0;
      m_user_cycles = 0; m_prev = '0; m_code = 0; m_pc = 0;
    end else begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && w < 0) w = i;
      acc  = m_req && inta;
      idle = !m_req && !m_svc;
      fire = idle && !m_kern && (m_user_cycles + 1 == Q);
      np = m_pend;
      if (acc) np[w] = 1'b0;
      if (fire) np[0] = 1'b1;
      for (int i = 0; i < 3; i++)
        if (irq[i] && !m_prev[i]) np[i+1] = 1'b1;
      if (idle && !m_kern) m_user_cycles = fire ? 0 : m_user_cycles + 1;
      if (userMode || acc) m_user_cycles = 0;
      if (idle) begin
        if (m_pend != 0 && !m_kern) m_req = 1;
      end else if (m_req) begin
        if (acc) begin
          m_req = 0; m_svc = 1; m_code = w + 1; m_pc = pc;
        end else if (kernelMode) m_req = 0;
      end else if (clearIntr) begin
        m_svc = 0; m_code = 0;
      end
      if (userMode) m_kern = 0;
      if (kernelMode) m_kern = 1;
      if (acc) m_kern = 1;
      m_pend = np;
      m_prev = irq;
    end
    #1;
  endtask

  task automatic pulse_user();
    userMode = 1; tick(); userMode = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++; $display("FAIL reset_intr: got %0b want 0", intr);
    end
    n_cmp++;
    if (intrCode !== 32'd0) begin
      n_bad++; $display("FAIL reset_code: got %0h want 0", intrCode);
    end
    n_cmp++;
    if (intrPc !== 32'd0) begin
      n_bad++; $display("FAIL reset_pc: got %0h want 0", intrPc);
    end
    n_cmp++;
    if (inKernel !== 1'b1) begin
      n_bad++; $display("FAIL reset_kern: got %0b want 1", inKernel);
    end
  endtask

  task automatic test_timer();
    int n;
    pulse_user();
    n = 1;
    while (intr !== 1'b1 && n < 30) begin
      tick(); n++;
    end
    n_cmp++;
    if (n !== 10) begin
      n_bad++; $display("FAIL timer_latency: got %0d want 10", n);
    end
    pc = 32'h40; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd1 || intrPc !== 32'h40 || inKernel !== 1'b1
        || intr !== 1'b0) begin
      n_bad++;
      $display("FAIL timer_accept: got code %0h pc %0h k %0b i %0b want 1 40 1 0",
               intrCode, intrPc, inKernel, intr);
    end
    clearIntr = 1; tick(); clearIntr = 0;
  endtask

  task automatic test_ext();
    pulse_user();
    irq = 3'b010; tick();
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++; $display("FAIL ext_early: got %0b want 0", intr);
    end
    tick();
    n_cmp++;
    if (intr !== 1'b1) begin
      n_bad++; $display("FAIL ext_req: got %0b want 1", intr);
    end
    pc = 32'h100; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd3 || intrPc !== 32'h100) begin
      n_bad++;
      $display("FAIL ext_code: got %0h/%0h want 3/100", intrCode, intrPc);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    n_cmp++;
    if (intrCode !== 32'd0 || intr !== 1'b0 || intrPc !== 32'h100) begin
      n_bad++;
      $display("FAIL ext_clear: got code %0h intr %0b pc %0h want 0 0 100",
               intrCode, intr, intrPc);
    end
    irq = 3'b000; tick();
  endtask

  task automatic test_simultaneous();
    pulse_user();
    irq = 3'b101; tick(); tick();
    pc = 32'h200; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd2) begin
      n_bad++; $display("FAIL simul_first: got %0h want 2", intrCode);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    pulse_user(); tick();
    n_cmp++;
    if (intr !== 1'b1) begin
      n_bad++; $display("FAIL simul_rereq: got %0b want 1", intr);
    end
    pc = 32'h204; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd4 || intrPc !== 32'h204) begin
      n_bad++;
      $display("FAIL simul_second: got %0h/%0h want 4/204", intrCode, intrPc);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    irq = 3'b000; tick();
  endtask

  task automatic test_in_service();
    pulse_user();
    irq = 3'b010; tick(); tick();
    pc = 32'h300; inta = 1; tick(); inta = 0;
    irq = 3'b011; tick(); tick(); tick();
    n_cmp++;
    if (intr !== 1'b0 || intrCode !== 32'd3) begin
      n_bad++;
      $display("FAIL svc_hold: got intr %0b code %0h want 0 3", intr, intrCode);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    tick(); tick();
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++; $display("FAIL svc_kernel_wait: got %0b want 0", intr);
    end
    pulse_user();
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++; $display("FAIL svc_user_same: got %0b want 0", intr);
    end
    tick();
    n_cmp++;
    if (intr !== 1'b1) begin
      n_bad++; $display("FAIL svc_user_next: got %0b want 1", intr);
    end
    pc = 32'h304; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd2) begin
      n_bad++; $display("FAIL svc_late_code: got %0h want 2", intrCode);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    irq = 3'b000; tick();
  endtask

  task automatic test_idle_kernel();
    clearIntr = 1; tick(); clearIntr = 0;
    n_cmp++;
    if (intr !== 1'b0 || intrCode !== 32'd0 || intrPc !== 32'h304
        || inKernel !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_clear: got %0b %0h %0h %0b want 0 0 304 1",
               intr, intrCode, intrPc, inKernel);
    end
    pulse_user();
    irq = 3'b100; tick(); tick();
    kernelMode = 1; tick(); kernelMode = 0;
    n_cmp++;
    if (intr !== 1'b0 || inKernel !== 1'b1) begin
      n_bad++;
      $display("FAIL req_withdraw: got intr %0b k %0b want 0 1", intr, inKernel);
    end
    pulse_user(); tick();
    n_cmp++;
    if (intr !== 1'b1) begin
      n_bad++; $display("FAIL req_retained: got %0b want 1", intr);
    end
    pc = 32'h400; inta = 1; tick(); inta = 0;
    n_cmp++;
    if (intrCode !== 32'd4) begin
      n_bad++; $display("FAIL retained_code: got %0h want 4", intrCode);
    end
    clearIntr = 1; tick(); clearIntr = 0;
    irq = 3'b000; tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    pulse_user();
    irq = 3'b010; tick(); tick();
    pc = 32'h500; inta = 1; tick(); inta = 0;
    irq = 3'b011; tick();
    reset = 1; irq = 3'b000; tick(); reset = 0;
    n_cmp++;
    if (intr !== 1'b0 || intrCode !== 32'd0 || intrPc !== 32'd0
        || inKernel !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset: got %0b %0h %0h %0b want 0 0 0 1",
               intr, intrCode, intrPc, inKernel);
    end
    pulse_user();
    seen = 0;
    repeat (5) begin
      tick();
      if (intr === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL midreset_dropped: got request want none");
    end
    kernelMode = 1; tick(); kernelMode = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      pc         = $urandom;
      inta       = ($urandom_range(1) == 0);
      clearIntr  = ($urandom_range(4) == 0);
      userMode   = ($urandom_range(9) == 0);
      kernelMode = ($urandom_range(19) == 0);
      reset      = ($urandom_range(299) == 0);
      tick();
      n_cmp++;
      if (intr !== m_req || intrCode !== m_code || intrPc !== m_pc
          || inKernel !== m_kern) begin
        n_bad++;
        $display("FAIL random[%0d]: got %0b %0h %0h %0b want %0b %0h %0h %0b",
                 c, intr, intrCode, intrPc, inKernel,
                 m_req, m_code, m_pc, m_kern);
      end
    end
    reset = 0; inta = 0; clearIntr = 0; userMode = 0; kernelMode = 0;
  endtask

  initial begin
    reset = 1; irq = '0; pc = '0; inta = 0;
    clearIntr = 0; userMode = 0; kernelMode = 0;
    test_reset();
    test_timer();
    test_ext();
    test_simultaneous();
    test_in_service();
    test_idle_kernel();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
